// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared geometry and game-mode constants for obstacle and game logic
// Purpose: common field widths, screen bounds and gamemode encodings.
// Ports: none (package).
package game_pkg;

  localparam int NUM_OBS     = 10;
  localparam int X_FIELD_W   = 10;
  localparam int Y_FIELD_W   = 9;
  localparam int X_SLOT_W    = 2 * X_FIELD_W;
  localparam int Y_SLOT_W    = 2 * Y_FIELD_W;

  localparam int UPPER_BOUND = 120;
  localparam int LOWER_BOUND = 360;
  localparam int SCREEN_W    = 640;

  localparam logic [1:0] MODE_INIT  = 2'b00;
  localparam logic [1:0] MODE_PLAY  = 2'b01;
  localparam logic [1:0] MODE_PAUSE = 2'b10;
  localparam logic [1:0] MODE_OVER  = 2'b11;

endpackage

// File: rtl/obs_lfsr.sv
// rtl/obs_lfsr.sv - 16-bit Fibonacci LFSR driving obstacle randomisation
// Purpose: free-running pseudo-random source, advances every clock.
// Ports:
//   clk   in   game clock
//   rst_n in   asynchronous active-low reset, loads SEED
//   state out  current 16-bit LFSR value
module obs_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Taps 16,14,13,11 of a right-shifting register sit at bits 0,2,3,5.
  // A non-zero seed can never reach the all-zero lock-up state.
  always_comb begin
    state_d = {state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5], state_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/obstacle_manager.sv
// rtl/obstacle_manager.sv - spawns, scrolls and retires obstacles, counts retirements
// Purpose: owns NUM_OBS obstacle slots and publishes them as packed buses.
// Ports:
//   clk        in   game clock
//   rst_n      in   asynchronous active-low reset
//   gamemode   in   00 init, 01 play, 10 pause, 11 over
//   obstacle_x out  slot k: [k*20 +: 10] left, [k*20+10 +: 10] right
//   obstacle_y out  slot k: [k*18 +: 9] top, [k*18+9 +: 9] bottom
//   passed_cnt out  obstacles retired since the last init
module obstacle_manager
  import game_pkg::*;
#(
  parameter int          NUM_OBS       = game_pkg::NUM_OBS,
  parameter int          SCREEN_W      = game_pkg::SCREEN_W,
  parameter int          UPPER_BOUND   = game_pkg::UPPER_BOUND,
  parameter int          LOWER_BOUND   = game_pkg::LOWER_BOUND,
  parameter int          OBS_W         = 40,
  parameter int          MIN_H         = 40,
  parameter int          H_STEP        = 8,
  parameter int          SCROLL_SPEED  = 4,
  parameter int          SPAWN_MIN_GAP = 40,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    gamemode,
  output logic [NUM_OBS*X_SLOT_W-1:0]   obstacle_x,
  output logic [NUM_OBS*Y_SLOT_W-1:0]   obstacle_y,
  output logic [15:0]                   passed_cnt
);

  // Counter must hold the largest reload, SPAWN_MIN_GAP + 31.
  localparam int CNT_W = $clog2(SPAWN_MIN_GAP + 32);

  localparam logic [X_FIELD_W-1:0] SPEED_X   = X_FIELD_W'(SCROLL_SPEED);
  localparam logic [X_FIELD_W-1:0] SPAWN_L   = X_FIELD_W'(SCREEN_W - OBS_W);
  localparam logic [X_FIELD_W-1:0] SPAWN_R   = X_FIELD_W'(SCREEN_W);
  localparam logic [Y_FIELD_W-1:0] UPPER_Y   = Y_FIELD_W'(UPPER_BOUND);
  localparam logic [Y_FIELD_W-1:0] LOWER_Y   = Y_FIELD_W'(LOWER_BOUND);
  localparam logic [Y_FIELD_W-1:0] MIN_H_Y   = Y_FIELD_W'(MIN_H);
  localparam logic [Y_FIELD_W-1:0] H_STEP_Y  = Y_FIELD_W'(H_STEP);
  localparam logic [CNT_W-1:0]     GAP_CNT   = CNT_W'(SPAWN_MIN_GAP);

  logic [X_FIELD_W-1:0] left_q  [NUM_OBS];
  logic [X_FIELD_W-1:0] left_d  [NUM_OBS];
  logic [X_FIELD_W-1:0] right_q [NUM_OBS];
  logic [X_FIELD_W-1:0] right_d [NUM_OBS];
  logic [Y_FIELD_W-1:0] top_q   [NUM_OBS];
  logic [Y_FIELD_W-1:0] top_d   [NUM_OBS];
  logic [Y_FIELD_W-1:0] bot_q   [NUM_OBS];
  logic [Y_FIELD_W-1:0] bot_d   [NUM_OBS];

  logic [15:0]      passed_cnt_q, passed_cnt_d;
  logic [CNT_W-1:0] spawn_cnt_q,  spawn_cnt_d;

  logic [15:0]          lfsr;
  logic [5:0]           lfsr_unused;
  logic [NUM_OBS-1:0]   empty_q;
  logic [NUM_OBS-1:0]   spawn_sel;
  logic                 free_found;
  logic [15:0]          retire_cnt;
  logic [Y_FIELD_W-1:0] new_h;
  logic [Y_FIELD_W-1:0] new_top;
  logic [Y_FIELD_W-1:0] new_bot;
  logic [CNT_W-1:0]     reload;

  obs_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr)
  );

  assign lfsr_unused = {lfsr[15:13], lfsr[7:5]};

  // Spawn geometry from the current LFSR value: bit 0 picks the anchor edge,
  // bits 4:1 the height, bits 12:8 the extra spawn gap.
  always_comb begin
    new_h   = MIN_H_Y + H_STEP_Y * Y_FIELD_W'(lfsr[4:1]);
    new_top = lfsr[0] ? (LOWER_Y - new_h) : UPPER_Y;
    new_bot = lfsr[0] ? LOWER_Y : (UPPER_Y + new_h);
    reload  = GAP_CNT + CNT_W'(lfsr[12:8]);
  end

  // Free-slot search works on registered state, so a slot retiring this
  // clock still looks occupied and is only reused on the following clock.
  always_comb begin
    free_found = 1'b0;
    spawn_sel  = '0;
    for (int k = 0; k < NUM_OBS; k++) begin
      empty_q[k] = (left_q[k] == '0) && (right_q[k] == '0) &&
                   (top_q[k] == '0) && (bot_q[k] == '0);
      if (!free_found && empty_q[k]) begin
        spawn_sel[k] = 1'b1;
        free_found   = 1'b1;
      end
    end
  end

  always_comb begin
    left_d       = left_q;
    right_d      = right_q;
    top_d        = top_q;
    bot_d        = bot_q;
    passed_cnt_d = passed_cnt_q;
    spawn_cnt_d  = spawn_cnt_q;
    retire_cnt   = '0;

    case (gamemode)
      MODE_INIT: begin
        for (int k = 0; k < NUM_OBS; k++) begin
          left_d[k]  = '0;
          right_d[k] = '0;
          top_d[k]   = '0;
          bot_d[k]   = '0;
        end
        passed_cnt_d = '0;
        spawn_cnt_d  = GAP_CNT;
      end

      MODE_PLAY: begin
        for (int k = 0; k < NUM_OBS; k++) begin
          if (!empty_q[k]) begin
            if (right_q[k] <= SPEED_X) begin
              left_d[k]  = '0;
              right_d[k] = '0;
              top_d[k]   = '0;
              bot_d[k]   = '0;
              retire_cnt = retire_cnt + 16'd1;
            end else begin
              right_d[k] = right_q[k] - SPEED_X;
              // Left edge clips at the screen edge while the right edge is still visible.
              left_d[k]  = (left_q[k] > SPEED_X) ? (left_q[k] - SPEED_X) : '0;
            end
          end
        end
        passed_cnt_d = passed_cnt_q + retire_cnt;

        if (spawn_cnt_q != '0) begin
          spawn_cnt_d = spawn_cnt_q - CNT_W'(1);
        end else if (free_found) begin
          // The chosen slot was empty, so the scroll loop never touched it.
          for (int k = 0; k < NUM_OBS; k++) begin
            if (spawn_sel[k]) begin
              left_d[k]  = SPAWN_L;
              right_d[k] = SPAWN_R;
              top_d[k]   = new_top;
              bot_d[k]   = new_bot;
            end
          end
          spawn_cnt_d = reload;
        end
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OBS; k++) begin
        left_q[k]  <= '0;
        right_q[k] <= '0;
        top_q[k]   <= '0;
        bot_q[k]   <= '0;
      end
      passed_cnt_q <= '0;
      spawn_cnt_q  <= GAP_CNT;
    end else begin
      left_q       <= left_d;
      right_q      <= right_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      passed_cnt_q <= passed_cnt_d;
      spawn_cnt_q  <= spawn_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_OBS; k++) begin : g_pack
    assign obstacle_x[k*X_SLOT_W +: X_FIELD_W]             = left_q[k];
    assign obstacle_x[k*X_SLOT_W + X_FIELD_W +: X_FIELD_W] = right_q[k];
    assign obstacle_y[k*Y_SLOT_W +: Y_FIELD_W]             = top_q[k];
    assign obstacle_y[k*Y_SLOT_W + Y_FIELD_W +: Y_FIELD_W] = bot_q[k];
  end

  assign passed_cnt = passed_cnt_q;

endmodule

// File: tb/tb_obstacle_manager.sv
// tb/tb_obstacle_manager.sv - directed self-checking bench for obstacle_manager
module tb_obstacle_manager;
  import game_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   gm, gm2;
  logic [199:0] ox, ox2;
  logic [179:0] oy, oy2;
  logic [15:0]  pc, pc2;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] r_last;

  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, seed ACE1, steps on every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  obstacle_manager #(
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gamemode   (gm),
    .obstacle_x (ox),
    .obstacle_y (oy),
    .passed_cnt (pc)
  );

  obstacle_manager #(
    .SCREEN_W      (1023),
    .SCROLL_SPEED  (1),
    .SPAWN_MIN_GAP (1),
    .LFSR_SEED     (16'hACE1)
  ) dut_full (
    .clk        (clk),
    .rst_n      (rst_n),
    .gamemode   (gm2),
    .obstacle_x (ox2),
    .obstacle_y (oy2),
    .passed_cnt (pc2)
  );

  function automatic logic [9:0] xl(input logic [199:0] b, input int k);
    return b[k*20 +: 10];
  endfunction
  function automatic logic [9:0] xr(input logic [199:0] b, input int k);
    return b[k*20+10 +: 10];
  endfunction
  function automatic logic [8:0] yt(input logic [179:0] b, input int k);
    return b[k*18 +: 9];
  endfunction
  function automatic logic [8:0] yb(input logic [179:0] b, input int k);
    return b[k*18+9 +: 9];
  endfunction

  function automatic logic [8:0] exp_top(input logic [15:0] r);
    logic [8:0] h;
    h = 9'd40 + 9'd8 * {5'd0, r[4:1]};
    return r[0] ? (9'd360 - h) : 9'd120;
  endfunction
  function automatic logic [8:0] exp_bot(input logic [15:0] r);
    logic [8:0] h;
    h = 9'd40 + 9'd8 * {5'd0, r[4:1]};
    return r[0] ? 9'd360 : (9'd120 + h);
  endfunction

  function automatic int active(input logic [199:0] bx, input logic [179:0] by);
    int n;
    n = 0;
    for (int k = 0; k < 10; k++)
      if (bx[k*20 +: 20] != 20'd0 || by[k*18 +: 18] != 18'd0) n++;
    return n;
  endfunction

  // Remembers the LFSR value the DUT uses at the upcoming edge.
  task automatic tick();
    r_last = m_lfsr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gm    = MODE_INIT;
    gm2   = MODE_INIT;
    #12;
    checks++; if (ox !== 200'd0) begin errors++; $display("FAIL reset_x: got %h expected 0", ox); end
    checks++; if (oy !== 180'd0) begin errors++; $display("FAIL reset_y: got %h expected 0", oy); end
    checks++; if (pc !== 16'd0)  begin errors++; $display("FAIL reset_cnt: got %0d expected 0", pc); end
    rst_n = 1'b1;
    repeat (100) tick();
    checks++; if (ox !== 200'd0 || oy !== 180'd0) begin errors++; $display("FAIL init_hold_bus: got x=%h y=%h expected 0", ox, oy); end
    checks++; if (pc !== 16'd0) begin errors++; $display("FAIL init_hold_cnt: got %0d expected 0", pc); end
  endtask

  task automatic test_spawn();
    logic [15:0] r_sp;
    gm = MODE_PLAY;
    repeat (40) tick();
    checks++; if (ox !== 200'd0) begin errors++; $display("FAIL spawn_early: got %h expected 0 after 40 play edges", ox); end
    tick();
    r_sp = r_last;
    checks++; if (xl(ox, 0) !== 10'd600 || xr(ox, 0) !== 10'd640)
      begin errors++; $display("FAIL spawn_x: got %0d/%0d expected 600/640", xl(ox, 0), xr(ox, 0)); end
    checks++; if (yt(oy, 0) !== exp_top(r_sp) || yb(oy, 0) !== exp_bot(r_sp))
      begin errors++; $display("FAIL spawn_y: got %0d/%0d expected %0d/%0d", yt(oy, 0), yb(oy, 0), exp_top(r_sp), exp_bot(r_sp)); end
    checks++; if (active(ox, oy) !== 1) begin errors++; $display("FAIL spawn_count: got %0d expected 1", active(ox, oy)); end
    tick();
    checks++; if (xl(ox, 0) !== 10'd596 || xr(ox, 0) !== 10'd636)
      begin errors++; $display("FAIL first_scroll: got %0d/%0d expected 596/636", xl(ox, 0), xr(ox, 0)); end
  endtask

  task automatic test_scroll_retire();
    logic [8:0]  t0, b0;
    logic [15:0] pcb;
    t0 = yt(oy, 0);
    b0 = yb(oy, 0);
    repeat (148) tick();
    checks++; if (xl(ox, 0) !== 10'd4 || xr(ox, 0) !== 10'd44)
      begin errors++; $display("FAIL scroll_148: got %0d/%0d expected 4/44", xl(ox, 0), xr(ox, 0)); end
    tick();
    checks++; if (xl(ox, 0) !== 10'd0 || xr(ox, 0) !== 10'd40)
      begin errors++; $display("FAIL left_edge: got %0d/%0d expected 0/40", xl(ox, 0), xr(ox, 0)); end
    tick();
    checks++; if (xl(ox, 0) !== 10'd0 || xr(ox, 0) !== 10'd36)
      begin errors++; $display("FAIL left_saturate: got %0d/%0d expected 0/36", xl(ox, 0), xr(ox, 0)); end
    repeat (8) tick();
    checks++; if (xl(ox, 0) !== 10'd0 || xr(ox, 0) !== 10'd4 || yt(oy, 0) !== t0 || yb(oy, 0) !== b0)
      begin errors++; $display("FAIL pre_retire: got x=%0d/%0d y=%0d/%0d expected 0/4 y=%0d/%0d", xl(ox, 0), xr(ox, 0), yt(oy, 0), yb(oy, 0), t0, b0); end
    pcb = pc;
    tick();
    checks++; if (ox[19:0] !== 20'd0 || oy[17:0] !== 18'd0)
      begin errors++; $display("FAIL retire_clear: got x=%h y=%h expected 0", ox[19:0], oy[17:0]); end
    checks++; if (pc !== pcb + 16'd1) begin errors++; $display("FAIL retire_cnt: got %0d expected %0d", pc, pcb + 16'd1); end
  endtask

  task automatic test_pause();
    logic [199:0] sx;
    logic [179:0] sy;
    logic [15:0]  sp;
    bit           same;
    int           n_act;
    gm = MODE_PAUSE;
    sx = ox; sy = oy; sp = pc; same = 1'b1;
    repeat (50) begin
      tick();
      if (ox !== sx || oy !== sy || pc !== sp) same = 1'b0;
    end
    checks++; if (!same) begin errors++; $display("FAIL pause_hold: got x=%h expected x=%h", ox, sx); end
    gm = MODE_PLAY;
    tick();
    n_act = 0;
    for (int k = 0; k < 10; k++) begin
      if (xr(sx, k) > 10'd4) begin
        n_act++;
        checks++;
        if (xr(ox, k) !== xr(sx, k) - 10'd4 || yt(oy, k) !== yt(sy, k))
          begin errors++; $display("FAIL resume_scroll: slot %0d got right %0d expected %0d", k, xr(ox, k), xr(sx, k) - 10'd4); end
      end
    end
    checks++; if (n_act == 0) begin errors++; $display("FAIL resume_active: got 0 active slots expected at least 1"); end
  endtask

  task automatic test_full();
    int          n;
    int          idx;
    bit          ok;
    logic [15:0] pcb;
    logic [15:0] r_sp;
    gm2 = MODE_PLAY;
    n = 0;
    while (active(ox2, oy2) != 10 && n < 2000) begin tick(); n++; end
    checks++; if (active(ox2, oy2) != 10) begin errors++; $display("FAIL full_fill: got %0d active expected 10", active(ox2, oy2)); end
    tick();
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (active(ox2, oy2) != 10) ok = 1'b0;
      for (int k = 0; k < 10; k++) if (xr(ox2, k) == 10'd1023) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL full_no_spawn: got %0d active expected 10 with no new spawn", active(ox2, oy2)); end
    pcb = pc2;
    n = 0;
    while (active(ox2, oy2) == 10 && n < 3000) begin pcb = pc2; tick(); n++; end
    idx = -1;
    for (int k = 9; k >= 0; k--) if (ox2[k*20 +: 20] == 20'd0 && oy2[k*18 +: 18] == 18'd0) idx = k;
    checks++; if (active(ox2, oy2) != 9) begin errors++; $display("FAIL full_retire: got %0d active expected 9", active(ox2, oy2)); end
    checks++; if (pc2 !== pcb + 16'd1) begin errors++; $display("FAIL full_retire_cnt: got %0d expected %0d", pc2, pcb + 16'd1); end
    checks++; if (idx != 0) begin errors++; $display("FAIL full_retire_slot: got %0d expected 0", idx); end
    if (idx < 0) idx = 0;
    tick();
    r_sp = r_last;
    checks++; if (xl(ox2, idx) !== 10'd983 || xr(ox2, idx) !== 10'd1023)
      begin errors++; $display("FAIL refill_x: got %0d/%0d expected 983/1023", xl(ox2, idx), xr(ox2, idx)); end
    checks++; if (yt(oy2, idx) !== exp_top(r_sp) || yb(oy2, idx) !== exp_bot(r_sp))
      begin errors++; $display("FAIL refill_y: got %0d/%0d expected %0d/%0d", yt(oy2, idx), yb(oy2, idx), exp_top(r_sp), exp_bot(r_sp)); end
  endtask

  task automatic test_over_init();
    logic [199:0] sx;
    logic [179:0] sy;
    logic [15:0]  sp;
    bit           same;
    gm = MODE_OVER;
    sx = ox; sy = oy; sp = pc; same = 1'b1;
    checks++; if (sp == 16'd0) begin errors++; $display("FAIL over_pre_cnt: got 0 expected non-zero"); end
    repeat (10) begin
      tick();
      if (ox !== sx || oy !== sy || pc !== sp) same = 1'b0;
    end
    checks++; if (!same) begin errors++; $display("FAIL over_hold: got cnt %0d expected %0d", pc, sp); end
    gm = MODE_INIT;
    tick();
    checks++; if (ox !== 200'd0 || oy !== 180'd0) begin errors++; $display("FAIL init_clear_bus: got x=%h expected 0", ox); end
    checks++; if (pc !== 16'd0) begin errors++; $display("FAIL init_clear_cnt: got %0d expected 0", pc); end
  endtask

  task automatic test_async_reset();
    logic [15:0] r_sp;
    gm = MODE_PLAY;
    repeat (45) tick();
    checks++; if (ox === 200'd0) begin errors++; $display("FAIL async_pre: got empty bus expected an active slot"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ox !== 200'd0 || oy !== 180'd0) begin errors++; $display("FAIL async_bus: got x=%h expected 0", ox); end
    checks++; if (pc !== 16'd0 || pc2 !== 16'd0) begin errors++; $display("FAIL async_cnt: got %0d/%0d expected 0", pc, pc2); end
    checks++; if (ox2 !== 200'd0) begin errors++; $display("FAIL async_bus2: got x=%h expected 0", ox2); end
    rst_n = 1'b1;
    repeat (40) tick();
    checks++; if (ox !== 200'd0) begin errors++; $display("FAIL post_reset_early: got %h expected 0", ox); end
    tick();
    r_sp = r_last;
    checks++; if (xl(ox, 0) !== 10'd600 || xr(ox, 0) !== 10'd640 || yt(oy, 0) !== exp_top(r_sp) || yb(oy, 0) !== exp_bot(r_sp))
      begin errors++; $display("FAIL post_reset_spawn: got %0d/%0d %0d/%0d expected 600/640 %0d/%0d", xl(ox, 0), xr(ox, 0), yt(oy, 0), yb(oy, 0), exp_top(r_sp), exp_bot(r_sp)); end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_scroll_retire();
    test_pause();
    test_full();
    test_over_init();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
